// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction-fetch sequencer in front of a combinational imem
//
// Owns the program counter, drives the imem address from it, and registers each
// fetched word into a single output stage toward decode with a valid/ready
// handshake. Handles start, branch/jump redirect, and halt-word detection.
//
// Ports:
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   start, start_addr             one-cycle pulse in IDLE; begin fetching at start_addr
//   redirect_valid, redirect_addr branch/jump taken; reload pc (RUN or HALT)
//   imem_addr, imem_rdata         imem address (= pc register) and its combinational data
//   out_valid, out_ready          output handshake toward decode
//   out_instr, out_pc             held instruction and the address it came from
//   busy, halted                  state == RUN, state == HALT
//   perf_fetch_count,             (FETCH_PERF_EN only) saturating count of captures
//   perf_stall_count              (FETCH_PERF_EN only) saturating count of RUN stall cycles
//
// Optional feature macro: FETCH_PERF_EN

module imem_fetch_ctrl #(
    parameter int             N         = 16,
    parameter int             R         = 6,
    parameter logic [N-1:0]   HALT_WORD = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [R-1:0]  start_addr,
    input  logic          redirect_valid,
    input  logic [R-1:0]  redirect_addr,
    output logic [R-1:0]  imem_addr,
    input  logic [N-1:0]  imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_instr,
    output logic [R-1:0]  out_pc,
    output logic          busy,
    output logic          halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   perf_fetch_count,
    output logic [15:0]   perf_stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [R-1:0]   pc_q, pc_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_instr_q, out_instr_d;
    logic [R-1:0]   out_pc_q, out_pc_d;

    logic           fire;
    logic           cap;
    logic           start_acc;
    logic           stall;

    assign fire      = out_valid_q & out_ready;
    // Capture only when the output stage is free or being drained this cycle,
    // and never in a cycle whose fetch address is about to be abandoned.
    assign cap       = (state_q == ST_RUN) & ~redirect_valid & (~out_valid_q | out_ready);
    assign start_acc = (state_q == ST_IDLE) & start;
    assign stall     = (state_q == ST_RUN) & out_valid_q & ~out_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        case (state_q)
            ST_IDLE: begin
                // redirect_valid is deliberately not looked at here: start wins.
                if (start) begin
                    pc_d    = start_addr;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // The held instruction is on the wrong path; drop it even if
                    // decode is accepting it this cycle.
                    pc_d        = redirect_addr;
                    out_valid_d = 1'b0;
                end else if (cap) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    if (imem_rdata == HALT_WORD) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + R'(1);
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d        = redirect_addr;
                    out_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end else if (fire) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign busy      = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (start_acc) begin
            perf_fetch_d = '0;
            perf_stall_d = '0;
        end else begin
            if (cap && perf_fetch_q != 16'hFFFF) begin
                perf_fetch_d = perf_fetch_q + 16'd1;
            end
            if (stall && perf_stall_q != 16'hFFFF) begin
                perf_stall_d = perf_stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_count = perf_fetch_q;
    assign perf_stall_count = perf_stall_q;
`else
    // Without the counters these terms have no consumer.
    logic unused_perf;
    assign unused_perf = start_acc ^ stall;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl

module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  start_addr;
    logic        redirect_valid;
    logic [5:0]  redirect_addr;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [5:0]  out_pc;
    logic        busy;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_count;
    logic [15:0] perf_stall_count;
`endif

    logic [15:0] mem [0:63];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_addr     (start_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_count (perf_fetch_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=halt; one output slot.
    int          m_mode;
    int          m_pc;
    bit          m_valid;
    int          m_instr;
    int          m_opc;
    int          m_fetch;
    int          m_stall;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0;
            m_fetch = 0; m_stall = 0;
        end else begin
            if (m_mode == 1 && m_valid && !out_ready && m_stall < 65535) m_stall++;
            if (m_mode == 0) begin
                if (start) begin
                    m_pc = start_addr; m_mode = 1; m_fetch = 0; m_stall = 0;
                end
            end else if (m_mode == 1) begin
                if (redirect_valid) begin
                    m_pc = redirect_addr; m_valid = 0;
                end else if (!m_valid || out_ready) begin
                    m_instr = mem[m_pc];
                    m_opc   = m_pc;
                    m_valid = 1;
                    if (m_fetch < 65535) m_fetch++;
                    if (m_instr == 16'hFFFF) m_mode = 2;
                    else m_pc = (m_pc + 1) % 64;
                end
            end else begin
                if (redirect_valid) begin
                    m_pc = redirect_addr; m_valid = 0; m_mode = 1;
                end else if (m_valid && out_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_busy", busy, m_mode == 1);
            chk("m_halted", halted, m_mode == 2);
            chk("m_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("m_out_instr", out_instr, m_instr);
                chk("m_out_pc", out_pc, m_opc);
            end
`ifdef FETCH_PERF_EN
            chk("m_perf_fetch", perf_fetch_count, m_fetch);
            chk("m_perf_stall", perf_stall_count, m_stall);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 0; redirect_valid = 0; out_ready = 1;
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic chk_out(input string name, input logic [15:0] ins, input logic [5:0] pc);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_instr"}, out_instr, ins);
        chk({name, "_pc"}, out_pc, pc);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hFFFF;
        reset_n = 0; start = 0; start_addr = 0; redirect_valid = 0; redirect_addr = 0;
        out_ready = 1;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        cyc(); cyc();
        reset_n = 1;

        // 1: straight-line program to halt
        cyc(); start = 1; start_addr = 0;
        cyc(); start = 0;
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_valid", out_valid, 0);
        cyc(); chk_out("t1_c2", 16'h1234, 0);
        cyc(); chk_out("t1_c3", 16'h5678, 1);
        cyc(); chk_out("t1_c4", 16'h9ABC, 2);
        cyc(); chk_out("t1_c5", 16'hFFFF, 3);
        cyc();
        chk("t1_c6_halted", halted, 1);
        chk("t1_c6_valid", out_valid, 0);
        chk("t1_c6_addr", imem_addr, 3);
        cyc();
        chk("t1_c7_addr", imem_addr, 3);

        // 2: stall in cycles 2-4
        do_reset();
        cyc(); start = 1; start_addr = 0;
        cyc(); start = 0;
        cyc(); out_ready = 0; chk_out("t2_c2", 16'h1234, 0);
        cyc(); chk_out("t2_c3", 16'h1234, 0);
        cyc(); chk_out("t2_c4", 16'h1234, 0);
        cyc(); out_ready = 1; chk_out("t2_c5", 16'h1234, 0);
        cyc(); chk_out("t2_c6", 16'h5678, 1);
`ifdef FETCH_PERF_EN
        chk("t2_perf_stall", perf_stall_count, 3);
`endif

        // 3: redirect while holding a valid instruction
        do_reset();
        cyc(); start = 1; start_addr = 0;
        cyc(); start = 0;
        cyc(); chk("t3_k_addr", imem_addr, 1);
        redirect_valid = 1; redirect_addr = 6'd40;
        cyc(); redirect_valid = 0;
        chk("t3_k1_valid", out_valid, 0);
        cyc(); chk_out("t3_k2", 16'h0128, 40);

        // 4: wrap-around 63 -> 0
        do_reset();
        mem[62] = 16'h0001; mem[63] = 16'h0002; mem[0] = 16'h0003;
        cyc(); start = 1; start_addr = 6'd62;
        cyc(); start = 0;
        cyc(); chk_out("t4_c2", 16'h0001, 62);
        cyc(); chk_out("t4_c3", 16'h0002, 63);
        cyc(); chk_out("t4_c4", 16'h0003, 0);
        cyc(); chk("t4_c5_halted", halted, 0);
        chk_out("t4_c5", 16'h5678, 1);
        mem[0] = 16'h1234;

        // 5: asynchronous reset during a stall
        do_reset();
        cyc(); start = 1; start_addr = 0;
        cyc(); start = 0; out_ready = 0;
        cyc(); chk_out("t5_c2", 16'h1234, 0);
        cyc();
        #2 reset_n = 0;
        #1;
        chk("t5_arst_valid", out_valid, 0);
        chk("t5_arst_busy", busy, 0);
        chk("t5_arst_addr", imem_addr, 0);
        chk("t5_arst_halted", halted, 0);
        cyc(); reset_n = 1; out_ready = 1;
        cyc(); start = 1; start_addr = 0;
        cyc(); start = 0;
        cyc(); chk_out("t5_restart", 16'h1234, 0);

        // 6: halt pending, drain, redirect back; start ignored in HALT and RUN
        do_reset();
        cyc(); start = 1; start_addr = 0;
        cyc(); start = 0;
        cyc(); cyc(); cyc();
        cyc(); out_ready = 0; start = 1; start_addr = 6'd20;
        chk("t6_c5_halted", halted, 1);
        cyc(); start = 0; out_ready = 1;
        chk_out("t6_c6", 16'hFFFF, 3);
        chk("t6_c6_addr", imem_addr, 3);
        cyc(); chk("t6_c7_valid", out_valid, 0);
        redirect_valid = 1; redirect_addr = 0;
        cyc(); redirect_valid = 0; start = 1; start_addr = 6'd20;
        chk("t6_c8_busy", busy, 1);
        cyc(); start = 0;
        chk_out("t6_c9", 16'h1234, 0);
        cyc(); chk_out("t6_c10", 16'h5678, 1);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
